// File: rtl/seq_mac_neuron.sv
// Time-multiplexed MAC neuron: one signed multiplier per cycle, programmable weights, saturating ReLU.
// Optional bias register enabled by defining NEURON_BIAS_EN (written at w_addr == NUM_INPUTS).
module seq_mac_neuron #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_W     = 8,
    parameter int FRAC_W     = 4,
`ifdef NEURON_BIAS_EN
    localparam int AW = $clog2(NUM_INPUTS + 1)
`else
    localparam int AW = $clog2(NUM_INPUTS)
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_we,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);
    localparam int ACC_W = 2 * DATA_W + $clog2(NUM_INPUTS) + 1;
    localparam int CW    = $clog2(NUM_INPUTS);
    localparam int PW    = 2 * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ACT   = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     rdy_en_q;
    logic signed [DATA_W-1:0] weight_q [NUM_INPUTS];
    logic signed [DATA_W-1:0] weight_d [NUM_INPUTS];

    logic                     accept;
    logic signed [DATA_W-1:0] weight_sel;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_init;
    logic signed [ACC_W-1:0]  t_shift;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_weight
            assign weight_d[gi] = (w_we && (w_addr == AW'(gi))) ? $signed(w_data) : weight_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '{default: '0};
        end else begin
            weight_q <= weight_d;
        end
    end

`ifdef NEURON_BIAS_EN
    logic signed [DATA_W-1:0] bias_q, bias_d;

    assign bias_d   = (w_we && (w_addr == AW'(NUM_INPUTS))) ? $signed(w_data) : bias_q;
    // Bias sits at the same binary point as the products, hence the FRAC_W pre-shift.
    assign acc_init = ACC_W'(bias_q) <<< FRAC_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else begin
            bias_q <= bias_d;
        end
    end
`else
    assign acc_init = '0;
`endif

    assign accept     = in_valid && in_ready;
    assign weight_sel = weight_q[count_q];
    assign prod       = $signed(in_data) * weight_sel;
    assign prod_ext   = {{(ACC_W - PW){prod[PW-1]}}, prod};
    assign t_shift    = acc_q >>> FRAC_W;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = acc_init + prod_ext;
                    count_d = CW'(1);
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    if (count_q == CW'(NUM_INPUTS - 1)) begin
                        count_d = '0;
                        state_d = S_ACT;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_ACT: begin
                if (t_shift < 0) begin
                    out_data_d = '0;
                end else if (t_shift > OUT_MAX) begin
                    out_data_d = OUT_MAX[DATA_W-1:0];
                end else begin
                    out_data_d = t_shift[DATA_W-1:0];
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            rdy_en_q   <= 1'b1;
        end
    end

    // in_ready stays low until the first clock after reset release.
    assign in_ready  = rdy_en_q && ((state_q == S_IDLE) || (state_q == S_ACCUM));
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_seq_mac_neuron.sv
// Directed self-checking bench for seq_mac_neuron (default parameters; bias cases under NEURON_BIAS_EN).
module tb_seq_mac_neuron;
    localparam int NUM_INPUTS = 4;
    localparam int DATA_W     = 8;
`ifdef NEURON_BIAS_EN
    localparam int AW = $clog2(NUM_INPUTS + 1);
`else
    localparam int AW = $clog2(NUM_INPUTS);
`endif

    logic              clk;
    logic              rst_n;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mac_neuron #(.NUM_INPUTS(NUM_INPUTS), .DATA_W(DATA_W), .FRAC_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input int addr, input logic signed [7:0] val);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = AW'(addr);
        w_data = val;
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    task automatic load_weights(input logic signed [7:0] w0, input logic signed [7:0] w1,
                                input logic signed [7:0] w2, input logic signed [7:0] w3);
        write_reg(0, w0);
        write_reg(1, w1);
        write_reg(2, w2);
        write_reg(3, w3);
    endtask

    // Streams four samples (optional idle gaps, optional same-cycle weight write at sample wk),
    // checks 2-cycle latency, optional out_ready stall, result and return to IDLE.
    task automatic infer(input string tag,
                         input logic signed [7:0] s0, input logic signed [7:0] s1,
                         input logic signed [7:0] s2, input logic signed [7:0] s3,
                         input int gap, input int wk, input logic signed [7:0] wv,
                         input int stall, input int exp);
        logic signed [7:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        out_ready = (stall == 0);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            @(negedge clk);
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    w_we     = 1'b0;
                    @(negedge clk);
                end
            end
            check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = s[k];
            if (k == wk) begin
                w_we   = 1'b1;
                w_addr = AW'(k);
                w_data = wv;
            end else begin
                w_we = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
        check_eq({tag, "_act_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_act_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check_eq({tag, "_lat_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd99;
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_hold_data"}, 32'(out_data), 32'(exp));
            check_eq({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        $display("infer %s: samples %0d %0d %0d %0d -> out_data=%0d (expected %0d)",
                 tag, s0, s1, s2, s3, out_data, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        $display("reset released");

        load_weights(8'sd16, 8'sd16, 8'sd16, 8'sd16);
        infer("basic", 8'sd1, 8'sd2, 8'sd3, 8'sd4, 0, -1, 8'sd0, 0, 10);
        infer("gaps", 8'sd1, 8'sd2, 8'sd3, 8'sd4, 2, -1, 8'sd0, 0, 10);
        infer("neg_shift", -8'sd1, -8'sd1, -8'sd1, 8'sd2, 0, -1, 8'sd0, 0, 0);

        load_weights(-8'sd16, 8'sd0, 8'sd0, 8'sd0);
        infer("relu", 8'sd5, 8'sd0, 8'sd0, 8'sd0, 0, -1, 8'sd0, 0, 0);

        load_weights(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        infer("sat", 8'sd127, 8'sd127, 8'sd127, 8'sd127, 0, -1, 8'sd0, 0, 127);

        load_weights(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        infer("trunc", 8'sd31, 8'sd1, 8'sd0, 8'sd0, 0, -1, 8'sd0, 0, 2);

        load_weights(8'sd16, 8'sd16, 8'sd16, 8'sd16);
        infer("wr_same", 8'sd1, 8'sd1, 8'sd1, 8'sd1, 0, 1, 8'sd48, 0, 4);
        infer("wr_next", 8'sd1, 8'sd1, 8'sd1, 8'sd1, 0, -1, 8'sd0, 0, 6);

        load_weights(8'sd32, -8'sd16, 8'sd16, 8'sd0);
        infer("stall", 8'sd5, 8'sd2, 8'sd1, 8'sd9, 0, -1, 8'sd0, 5, 9);
        infer("post_stall", 8'sd5, 8'sd2, 8'sd1, 8'sd9, 0, -1, 8'sd0, 0, 9);

        // Abort an inference with reset after two samples.
        load_weights(8'sd16, 8'sd16, 8'sd16, 8'sd16);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd7;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_post_ready", 32'(in_ready), 32'd1);
        check_eq("mid_post_data", 32'(out_data), 32'd0);
        $display("mid-inference reset applied");
        infer("after_rst", 8'sd10, 8'sd20, 8'sd30, 8'sd40, 0, -1, 8'sd0, 0, 0);

`ifdef NEURON_BIAS_EN
        load_weights(8'sd0, 8'sd0, 8'sd0, 8'sd0);
        write_reg(NUM_INPUTS, 8'sd3);
        infer("bias_pos", 8'sd9, -8'sd4, 8'sd100, 8'sd1, 0, -1, 8'sd0, 0, 3);
        write_reg(NUM_INPUTS, -8'sd3);
        infer("bias_neg", 8'sd9, -8'sd4, 8'sd100, 8'sd1, 0, -1, 8'sd0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
